// File: rtl/video_timing_pkg.sv
// Shared raster mode constants and helpers for the video timing generator.
package video_timing_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        hs_pol;
        logic        vs_pol;
        logic [4:0]  cordw;
    } timing_mode_t;

    localparam timing_mode_t MODE_640X480 = '{
        h_active: 16'd640,  h_fp: 16'd16,  h_sync: 16'd96, h_bp: 16'd48,
        v_active: 16'd480,  v_fp: 16'd10,  v_sync: 16'd2,  v_bp: 16'd33,
        hs_pol:   1'b0,     vs_pol: 1'b0,  cordw: 5'd10
    };

    localparam timing_mode_t MODE_1280X720 = '{
        h_active: 16'd1280, h_fp: 16'd110, h_sync: 16'd40, h_bp: 16'd220,
        v_active: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,  v_bp: 16'd20,
        hs_pol:   1'b1,     vs_pol: 1'b1,  cordw: 5'd11
    };

    localparam int unsigned MAX_DELAY = 15;

    // Total period of one axis (line or frame) in pixels or lines.
    function automatic int unsigned line_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register aligning sync/de with a downstream pixel pipeline.
module sync_delay_line #(
    parameter int unsigned      DEPTH   = 0,
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, en_i};
        assign q_o = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: coordinates, sync, data enable,
// line/frame strobes and a completed-frame counter, all driven from flops.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = MODE_640X480.h_active,
    parameter int unsigned H_FP     = MODE_640X480.h_fp,
    parameter int unsigned H_SYNC   = MODE_640X480.h_sync,
    parameter int unsigned H_BP     = MODE_640X480.h_bp,
    parameter int unsigned V_ACTIVE = MODE_640X480.v_active,
    parameter int unsigned V_FP     = MODE_640X480.v_fp,
    parameter int unsigned V_SYNC   = MODE_640X480.v_sync,
    parameter int unsigned V_BP     = MODE_640X480.v_bp,
    parameter logic        HS_POL   = MODE_640X480.hs_pol,
    parameter logic        VS_POL   = MODE_640X480.vs_pol,
    parameter int unsigned CORDW    = MODE_640X480.cordw,
    parameter int unsigned DELAY    = 0,
    parameter int unsigned FRAME_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [CORDW-1:0]   sx,
    output logic [CORDW-1:0]   sy,
    output logic               de_early,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (64'(H_TOTAL) > (64'd1 << CORDW) || 64'(V_TOTAL) > (64'd1 << CORDW)) begin : g_bad_cordw
        $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in CORDW bits");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $error("video_timing_gen: porch and sync widths must be non-zero");
    end
    if (DELAY > MAX_DELAY) begin : g_bad_delay
        $error("video_timing_gen: DELAY must be 0..15");
    end

    localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_ACTIVE);
    localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_ACTIVE);
    localparam logic [CORDW-1:0] HS_START = CORDW'(H_ACTIVE + H_FP);
    localparam logic [CORDW-1:0] HS_END   = CORDW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] VS_START = CORDW'(V_ACTIVE + V_FP);
    localparam logic [CORDW-1:0] VS_END   = CORDW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CORDW-1:0]   sx_q, sx_d;
    logic [CORDW-1:0]   sy_q, sy_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               de_early_q, de_early_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [2:0]         sync_q;

    // Sync/de flags are derived from the next coordinates so they sit in the
    // same cycle as the coordinates they describe.
    always_comb begin
        sx_d        = sx_q;
        sy_d        = sy_q;
        frame_cnt_d = frame_cnt_q;
        if (en) begin
            if (sx_q == H_LAST) begin
                sx_d = '0;
                if (sy_q == V_LAST) begin
                    sy_d        = '0;
                    frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                end else begin
                    sy_d = sy_q + CORDW'(1);
                end
            end else begin
                sx_d = sx_q + CORDW'(1);
            end
        end

        de_early_d    = (sx_d < H_ACT) && (sy_d < V_ACT);
        hs_d          = ((sx_d >= HS_START) && (sx_d < HS_END)) ? HS_POL : ~HS_POL;
        vs_d          = ((sy_d >= VS_START) && (sy_d < VS_END)) ? VS_POL : ~VS_POL;
        line_start_d  = en && (sx_d == '0);
        frame_start_d = en && (sx_d == '0) && (sy_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_q          <= '0;
            sy_q          <= '0;
            frame_cnt_q   <= '0;
            de_early_q    <= 1'b1;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            frame_cnt_q   <= frame_cnt_d;
            de_early_q    <= de_early_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // With DELAY=0 the line is a pass-through, so de tracks de_early exactly.
    sync_delay_line #(
        .DEPTH  (DELAY),
        .WIDTH  (3),
        .RST_VAL({~HS_POL, ~VS_POL, 1'b0})
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .en_i(en),
        .d_i ({hs_q, vs_q, de_early_q}),
        .q_o (sync_q)
    );

    assign sx          = sx_q;
    assign sy          = sy_q;
    assign frame_cnt   = frame_cnt_q;
    assign de_early    = de_early_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign {hsync, vsync, de} = sync_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: four instances (VGA, 720p, VGA with
// DELAY=3, and a tiny mode with FRAME_W=2) checked against an en-cycle model.
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic en_v = 1'b0, en_h = 1'b0, en_d = 1'b0, en_s = 1'b0;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [9:0]  v_sx, v_sy;   logic v_dee, v_hs, v_vs, v_de, v_ls, v_fs; logic [15:0] v_fc;
    logic [10:0] h_sx, h_sy;   logic h_dee, h_hs, h_vs, h_de, h_ls, h_fs; logic [15:0] h_fc;
    logic [9:0]  d_sx, d_sy;   logic d_dee, d_hs, d_vs, d_de, d_ls, d_fs; logic [15:0] d_fc;
    logic [4:0]  s_sx, s_sy;   logic s_dee, s_hs, s_vs, s_de, s_ls, s_fs; logic [1:0]  s_fc;

    video_timing_gen u_vga (
        .clk(clk), .rst(rst), .en(en_v), .sx(v_sx), .sy(v_sy), .de_early(v_dee),
        .hsync(v_hs), .vsync(v_vs), .de(v_de), .line_start(v_ls),
        .frame_start(v_fs), .frame_cnt(v_fc));

    video_timing_gen #(
        .H_ACTIVE(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
        .V_ACTIVE(720), .V_FP(5), .V_SYNC(5), .V_BP(20),
        .HS_POL(1'b1), .VS_POL(1'b1), .CORDW(11)
    ) u_720 (
        .clk(clk), .rst(rst), .en(en_h), .sx(h_sx), .sy(h_sy), .de_early(h_dee),
        .hsync(h_hs), .vsync(h_vs), .de(h_de), .line_start(h_ls),
        .frame_start(h_fs), .frame_cnt(h_fc));

    video_timing_gen #(.DELAY(3)) u_d3 (
        .clk(clk), .rst(rst), .en(en_d), .sx(d_sx), .sy(d_sy), .de_early(d_dee),
        .hsync(d_hs), .vsync(d_vs), .de(d_de), .line_start(d_ls),
        .frame_start(d_fs), .frame_cnt(d_fc));

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b0), .CORDW(5), .DELAY(2), .FRAME_W(2)
    ) u_sm (
        .clk(clk), .rst(rst), .en(en_s), .sx(s_sx), .sy(s_sy), .de_early(s_dee),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .line_start(s_ls),
        .frame_start(s_fs), .frame_cnt(s_fc));

    // Reference state: en-cycles since reset and whether the last edge advanced.
    longint unsigned n_v, n_h, n_d, n_s;
    logic pe_v, pe_h, pe_d, pe_s;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n_v <= 0; n_h <= 0; n_d <= 0; n_s <= 0;
            pe_v <= 1'b0; pe_h <= 1'b0; pe_d <= 1'b0; pe_s <= 1'b0;
        end else begin
            if (en_v) n_v <= n_v + 1;
            if (en_h) n_h <= n_h + 1;
            if (en_d) n_d <= n_d + 1;
            if (en_s) n_s <= n_s + 1;
            pe_v <= en_v; pe_h <= en_h; pe_d <= en_d; pe_s <= en_s;
        end
    end

    function automatic logic [63:0] pack(input logic [11:0] x, input logic [11:0] y,
                                         input logic dee, input logic hs, input logic vs,
                                         input logic de, input logic ls, input logic fs,
                                         input logic [15:0] fc);
        return {18'd0, x, y, dee, hs, vs, de, ls, fs, fc};
    endfunction

    // Expected outputs after n advancing cycles, straight from the raster rules.
    function automatic logic [63:0] model(input longint unsigned n, input logic pe,
        input longint unsigned ha, input longint unsigned hf, input longint unsigned hw,
        input longint unsigned hb, input longint unsigned va, input longint unsigned vf,
        input longint unsigned vw, input longint unsigned vb, input logic hp, input logic vp,
        input longint unsigned d, input longint unsigned fw);
        longint unsigned ht, vt, x, y, f, k, kx, ky;
        logic dee, hs, vs, de, ls, fs;
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        x = n % ht;
        y = (n / ht) % vt;
        f = (n / (ht * vt)) % (64'd1 << fw);
        dee = (x < ha) && (y < va);
        hs = ~hp; vs = ~vp; de = 1'b0;
        if (n >= d) begin
            k = n - d; kx = k % ht; ky = (k / ht) % vt;
            if (kx >= ha + hf && kx < ha + hf + hw) hs = hp;
            if (ky >= va + vf && ky < va + vf + vw) vs = vp;
            de = (kx < ha) && (ky < va);
        end
        ls = pe && (x == 0);
        fs = ls && (y == 0);
        return pack(12'(x), 12'(y), dee, hs, vs, de, ls, fs, 16'(f));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en_v = 1'b0; en_h = 1'b0; en_d = 1'b0; en_s = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] exp, got;
        @(negedge clk);
        exp = model(0, 1'b0, 640,16,96,48, 480,10,2,33, 1'b0,1'b0, 0, 16);
        got = pack(12'(v_sx), 12'(v_sy), v_dee, v_hs, v_vs, v_de, v_ls, v_fs, v_fc);
        checks++; if (got !== exp) begin errors++; $display("FAIL reset_vga got=%h exp=%h", got, exp); end
        exp = model(0, 1'b0, 1280,110,40,220, 720,5,5,20, 1'b1,1'b1, 0, 16);
        got = pack(12'(h_sx), 12'(h_sy), h_dee, h_hs, h_vs, h_de, h_ls, h_fs, h_fc);
        checks++; if (got !== exp) begin errors++; $display("FAIL reset_720 got=%h exp=%h", got, exp); end
        exp = model(0, 1'b0, 640,16,96,48, 480,10,2,33, 1'b0,1'b0, 3, 16);
        got = pack(12'(d_sx), 12'(d_sy), d_dee, d_hs, d_vs, d_de, d_ls, d_fs, d_fc);
        checks++; if (got !== exp) begin errors++; $display("FAIL reset_d3 got=%h exp=%h", got, exp); end
        exp = model(0, 1'b0, 16,2,3,4, 8,1,2,3, 1'b1,1'b0, 2, 2);
        got = pack(12'(s_sx), 12'(s_sy), s_dee, s_hs, s_vs, s_de, s_ls, s_fs, 16'(s_fc));
        checks++; if (got !== exp) begin errors++; $display("FAIL reset_sm got=%h exp=%h", got, exp); end
        checks++; if (d_de !== 1'b0) begin errors++; $display("FAIL reset_d3_de got=%b exp=0", d_de); end
        checks++; if (v_hs !== 1'b1) begin errors++; $display("FAIL reset_vga_hs got=%b exp=1", v_hs); end
        checks++; if (h_vs !== 1'b0) begin errors++; $display("FAIL reset_720_vs got=%b exp=0", h_vs); end
        checks++; if (v_dee !== 1'b1) begin errors++; $display("FAIL reset_vga_dee got=%b exp=1", v_dee); end
        rst = 1'b0;
    endtask

    task automatic test_vga_raster();
        logic [63:0] exp, got;
        int unsigned hs_min = 99999, hs_max = 0, period = 0, last = 0, nls = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            exp = model(n_v, pe_v, 640,16,96,48, 480,10,2,33, 1'b0,1'b0, 0, 16);
            got = pack(12'(v_sx), 12'(v_sy), v_dee, v_hs, v_vs, v_de, v_ls, v_fs, v_fc);
            checks++; if (got !== exp) begin errors++; $display("FAIL vga_state n=%0d got=%h exp=%h", n_v, got, exp); end
            if (c >= 600) begin
                if (v_hs == 1'b0) begin
                    if (int'(v_sx) < hs_min) hs_min = v_sx;
                    if (int'(v_sx) > hs_max) hs_max = v_sx;
                end
                if (v_ls) begin
                    if (nls > 0) period = c - last;
                    last = c; nls++;
                end
            end
            en_v = (c < 600) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        en_v = 1'b0;
        checks++; if (period != 800) begin errors++; $display("FAIL vga_line_period got=%0d exp=800", period); end
        checks++; if (hs_min != 656) begin errors++; $display("FAIL vga_hs_first got=%0d exp=656", hs_min); end
        checks++; if (hs_max != 751) begin errors++; $display("FAIL vga_hs_last got=%0d exp=751", hs_max); end
    endtask

    task automatic test_720p_raster();
        logic [63:0] exp, got;
        int unsigned hs_min = 99999, hs_max = 0, period = 0, last = 0, nls = 0;
        do_reset();
        for (int c = 0; c < 3800; c++) begin
            @(negedge clk);
            exp = model(n_h, pe_h, 1280,110,40,220, 720,5,5,20, 1'b1,1'b1, 0, 16);
            got = pack(12'(h_sx), 12'(h_sy), h_dee, h_hs, h_vs, h_de, h_ls, h_fs, h_fc);
            checks++; if (got !== exp) begin errors++; $display("FAIL 720_state n=%0d got=%h exp=%h", n_h, got, exp); end
            if (c >= 300) begin
                if (h_hs == 1'b1) begin
                    if (int'(h_sx) < hs_min) hs_min = h_sx;
                    if (int'(h_sx) > hs_max) hs_max = h_sx;
                end
                if (h_ls) begin
                    if (nls > 0) period = c - last;
                    last = c; nls++;
                end
            end
            en_h = (c < 300) ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        en_h = 1'b0;
        checks++; if (period != 1650) begin errors++; $display("FAIL 720_line_period got=%0d exp=1650", period); end
        checks++; if (hs_min != 1390) begin errors++; $display("FAIL 720_hs_first got=%0d exp=1390", hs_min); end
        checks++; if (hs_max != 1429) begin errors++; $display("FAIL 720_hs_last got=%0d exp=1429", hs_max); end
    endtask

    task automatic test_delay_stalls();
        logic [63:0] exp, got;
        int unsigned gap_at [3] = '{798, 800, 802};
        int unsigned gap_len[3] = '{1, 5, 17};
        int unsigned gap_left = 0, gi = 0;
        longint unsigned dee_rise = 0, de_rise = 0;
        logic prev_dee = 1'b1, prev_de = 1'b0;
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            exp = model(n_d, pe_d, 640,16,96,48, 480,10,2,33, 1'b0,1'b0, 3, 16);
            got = pack(12'(d_sx), 12'(d_sy), d_dee, d_hs, d_vs, d_de, d_ls, d_fs, d_fc);
            checks++; if (got !== exp) begin errors++; $display("FAIL d3_state n=%0d got=%h exp=%h", n_d, got, exp); end
            if (d_dee && !prev_dee) dee_rise = n_d;
            if (d_de && !prev_de) de_rise = n_d;
            prev_dee = d_dee; prev_de = d_de;
            if (gap_left == 0 && gi < 3 && n_d == gap_at[gi]) begin
                gap_left = gap_len[gi]; gi++;
            end
            if (gap_left > 0) begin en_d = 1'b0; gap_left--; end
            else en_d = 1'b1;
        end
        en_d = 1'b0;
        checks++; if (dee_rise != 800) begin errors++; $display("FAIL d3_dee_rise got=%0d exp=800", dee_rise); end
        checks++; if (de_rise != dee_rise + 3) begin errors++; $display("FAIL d3_de_lag got=%0d exp=%0d", de_rise, dee_rise + 3); end
    endtask

    task automatic test_random_stalls();
        logic [63:0] exp, got;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            exp = model(n_s, pe_s, 16,2,3,4, 8,1,2,3, 1'b1,1'b0, 2, 2);
            got = pack(12'(s_sx), 12'(s_sy), s_dee, s_hs, s_vs, s_de, s_ls, s_fs, 16'(s_fc));
            checks++; if (got !== exp) begin errors++; $display("FAIL sm_state n=%0d got=%h exp=%h", n_s, got, exp); end
            en_s = ($urandom_range(0, 9) < 6);
        end
        en_s = 1'b0;
    endtask

    task automatic test_frame_wrap();
        int unsigned seq [5] = '{1, 2, 3, 0, 1};
        int unsigned nfs = 0, dee_cnt = 0, vs_cnt = 0;
        do_reset();
        en_s = 1'b1;
        for (int c = 0; c < 1760; c++) begin
            @(negedge clk);
            if (s_fs) begin
                if (nfs < 5) begin
                    checks++;
                    if (s_fc !== 2'(seq[nfs])) begin errors++; $display("FAIL sm_frame_cnt idx=%0d got=%0d exp=%0d", nfs, s_fc, seq[nfs]); end
                end
                nfs++;
            end
            if (n_s >= 350 && n_s < 1750) begin
                if (s_dee) dee_cnt++;
                if (s_vs == 1'b0) vs_cnt++;
            end
        end
        en_s = 1'b0;
        checks++; if (nfs != 5) begin errors++; $display("FAIL sm_frame_pulses got=%0d exp=5", nfs); end
        checks++; if (dee_cnt != 512) begin errors++; $display("FAIL sm_de_cycles got=%0d exp=512", dee_cnt); end
        checks++; if (vs_cnt != 200) begin errors++; $display("FAIL sm_vs_cycles got=%0d exp=200", vs_cnt); end
    endtask

    task automatic test_single_pulse_wrap();
        logic [1:0] fc0;
        int unsigned nls, nfs;
        bit found = 0;
        do_reset();
        for (int c = 0; c < 600 && !found; c++) begin
            @(negedge clk);
            if (s_sx == 5'd24 && s_sy == 5'd13) found = 1;
            else en_s = 1'b1;
        end
        en_s = 1'b0;
        if (!found) begin
            checks++; errors++; $display("FAIL wrap_reach got=timeout exp=sx24_sy13");
        end else begin
            fc0 = s_fc;
            repeat (3) @(negedge clk);
            checks++; if (s_sx !== 5'd24 || s_ls !== 1'b0) begin errors++; $display("FAIL wrap_stall_hold sx=%0d ls=%b exp sx=24 ls=0", s_sx, s_ls); end
            en_s = 1'b1;
            @(negedge clk);
            en_s = 1'b0;
            checks++; if (s_sx !== 5'd0 || s_sy !== 5'd0) begin errors++; $display("FAIL wrap_coords got=%0d,%0d exp=0,0", s_sx, s_sy); end
            checks++; if (s_fc !== fc0 + 2'd1) begin errors++; $display("FAIL wrap_frame_cnt got=%0d exp=%0d", s_fc, fc0 + 2'd1); end
            nls = s_ls; nfs = s_fs;
            repeat (5) begin
                @(negedge clk);
                nls += s_ls; nfs += s_fs;
            end
            checks++; if (nls != 1) begin errors++; $display("FAIL wrap_line_pulses got=%0d exp=1", nls); end
            checks++; if (nfs != 1) begin errors++; $display("FAIL wrap_frame_pulses got=%0d exp=1", nfs); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] exp, got;
        bit found = 0;
        do_reset();
        en_s = 1'b1;
        for (int c = 0; c < 600 && !found; c++) begin
            @(negedge clk);
            if (s_sx == 5'd10 && s_sy == 5'd5) found = 1;
        end
        if (!found) begin
            checks++; errors++; $display("FAIL midrst_reach got=timeout exp=sx10_sy5");
        end else begin
            #1 rst = 1'b1;
            #1;
            got = pack(12'(s_sx), 12'(s_sy), s_dee, s_hs, s_vs, s_de, s_ls, s_fs, 16'(s_fc));
            exp = pack(12'd0, 12'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
            checks++; if (got !== exp) begin errors++; $display("FAIL midrst_async got=%h exp=%h", got, exp); end
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                exp = model(n_s, pe_s, 16,2,3,4, 8,1,2,3, 1'b1,1'b0, 2, 2);
                got = pack(12'(s_sx), 12'(s_sy), s_dee, s_hs, s_vs, s_de, s_ls, s_fs, 16'(s_fc));
                checks++; if (got !== exp) begin errors++; $display("FAIL midrst_resume n=%0d got=%h exp=%h", n_s, got, exp); end
            end
        end
        en_s = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vga_raster();
        test_720p_raster();
        test_delay_stalls();
        test_random_stalls();
        test_frame_wrap();
        test_single_pulse_wrap();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
